// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
// Runs classic T1/T2/T3/(TW)/T4 bus cycles for memory and I/O accesses.
// Every output is registered: the next-state logic also computes the
// next value of each bus pin, and one register stage drives the pins.
//
// Optional feature: define BUS_WAIT_TIMEOUT_EN to bound wait states.
// When defined, an access whose target holds ready low for WAIT_LIMIT
// wait states is aborted with a one-cycle err pulse instead of done.
// When undefined there is no wait counter and err is constant 0.
//
// Handshake: req is looked at only while the controller is idle. A
// request seen in IDLE is accepted on that clock edge (its fields are
// latched there) and busy rises on the same edge. req seen in any other
// state is ignored. On the bus side, ready is sampled on the edge that
// ends T3/TW; ready=1 completes the transfer, ready=0 inserts one TW.
//
// dbg_state exposes the FSM state for checkers:
//   0=IDLE 1=T1 2=T2 3=T3 4=TW 5=T4
module bus_cycle_controller #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              req_mio,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] address,
  output logic              MIO,
  output logic              ALE,
  output logic              RD_n,
  output logic              WR_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5
  } state_t;

  // Wait counter width; a limit of 0 or 1 still needs one bit.
  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  typedef logic [CNT_W-1:0] wcnt_t;

  state_t state;
  state_t next_state;

  // Direction of the access in flight, latched with the request.
  logic lat_write;

  // Decoded actions for the coming edge.
  logic accept;    // request accepted in IDLE
  logic capture;   // read data is valid on the bus this cycle
  logic abort;     // wait-state limit reached with ready still low
  logic strobe_ph; // next state keeps a strobe asserted
  logic drive_ph;  // next state keeps write data on the bus

`ifdef BUS_WAIT_TIMEOUT_EN
  wcnt_t wait_cnt;
`endif

  assign dbg_state = state;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the per-edge actions derived from it.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          next_state = T1;
        end
      end
      T1: next_state = T2;
      T2: next_state = T3;
      T3, TW: begin
        if (ready) begin
          capture    = ~lat_write;
          next_state = T4;
        end else begin
`ifdef BUS_WAIT_TIMEOUT_EN
          if (wait_cnt == wcnt_t'(WAIT_LIMIT)) begin
            abort      = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = TW;
          end
`else
          next_state = TW;
`endif
        end
      end
      T4:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are low from T2 until the transfer completes; write data is
  // driven from T2 through T4 so it stays stable past the WR_n rise.
  always_comb begin
    strobe_ph = (next_state == T2) || (next_state == T3) || (next_state == TW);
    drive_ph  = strobe_ph || (next_state == T4);
  end

  // Registered bus pins, request latches and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address   <= '0;
      MIO       <= 1'b0;
      data_out  <= '0;
      lat_write <= 1'b0;
      ALE       <= 1'b0;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      data_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      if (accept) begin
        address   <= req_addr;
        MIO       <= req_mio;
        data_out  <= req_wdata;
        lat_write <= req_write;
      end
      ALE     <= (next_state == T1);
      RD_n    <= ~(strobe_ph & ~lat_write);
      WR_n    <= ~(strobe_ph & lat_write);
      data_oe <= drive_ph & lat_write;
      busy    <= (next_state != IDLE);
      done    <= (next_state == T4);
      if (capture) begin
        rdata <= data_in;
      end
    end
  end

`ifdef BUS_WAIT_TIMEOUT_EN
  // Counts TW cycles of the current access; cleared on the way into T3.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state == T2) begin
      wait_cnt <= '0;
    end else if ((state == T3 || state == TW) && !ready && !abort) begin
      wait_cnt <= wait_cnt + wcnt_t'(1);
    end
  end

  // Abort pulse, one cycle, coincident with the return to IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= abort;
    end
  end
`else
  // No timeout logic: the abort pulse register is held at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else begin
      err <= abort;
    end
  end
`endif

endmodule
